seg_signed_mux: RTL
===================

SEG_SIGNED_MUX -- requirements
Module: seg_signed_mux

Interface
REQ-001 SHALL provide parameter DIGITS, default 4; number of physical digits, sign digit included, legal range 2..8.
REQ-002 SHALL provide parameter VAL_W, default 12; width of the two's-complement input value, legal range 2..32.
REQ-003 SHALL provide parameter REFRESH_DIV, default 100000; clk cycles per digit dwell, minimum 2.
REQ-004 SHALL provide port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-005 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL provide port val_in, input, VAL_W, signed value to display.
REQ-007 SHALL provide port load, input, 1, a request to capture val_in.
REQ-008 SHALL provide port busy, output, 1, high while a conversion is in progress.
REQ-009 SHALL provide port segment, output, 8, active-low pattern ordered {dp,g,f,e,d,c,b,a}.
REQ-010 SHALL provide port an, output, DIGITS, active-low digit enables; bit 0 is the rightmost digit.

Function
REQ-011 SHALL accept load only on an edge where load=1 and busy=0; a load while busy=1 SHALL be ignored with no queueing.
REQ-012 SHALL, on acceptance, capture the sign and the magnitude |val_in| as an unsigned VAL_W-bit value; -2^(VAL_W-1) SHALL give magnitude 2^(VAL_W-1).
REQ-013 SHALL convert the magnitude to DIGITS-1 BCD digits by sequential shift-add-3, one bit per cycle.
REQ-014 SHALL hold busy high for exactly VAL_W+1 cycles, starting the cycle after acceptance.
REQ-015 SHALL set a sticky overflow flag if a 1 is shifted out of the top BCD digit.
REQ-016 SHALL update the displayed sign, digits and overflow atomically on the edge where busy falls; the previous value SHALL stay on display until then.
REQ-017 SHALL use a refresh counter 0..REFRESH_DIV-1 and advance the digit index 0->1->...->DIGITS-1->0 on each wrap.
REQ-018 SHALL drive an with exactly one bit low, at the current index, once scanning has started.
REQ-019 SHALL drive segment from registers, aligned to the same edge as an.
REQ-020 SHALL use these digit codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, minus=BF, blank=FF, E=86 (hex).
REQ-021 SHALL, on overflow, show 86 on every magnitude digit and the normal sign code on the sign digit.
REQ-022 SHALL display zero as positive; a minus sign SHALL never appear with zero.

Reset
REQ-023 SHALL, while rst=1, force segment=FF, an all ones, busy=0, refresh counter=0, digit index=0, displayed value=+0, overflow=0.
REQ-024 SHALL make reset abort any conversion in progress; after rst falls, the first counter wrap SHALL light digit 0.

Configuration
REQ-025 SHALL apply leading-zero blanking when SEG_SIGNED_MUX_LZB_EN is defined:
- leading-zero magnitude digits show FF;
- digit 0 always shows its numeral;
- the minus sign sits immediately left of the most-significant shown digit;
- all digits further left show FF.
REQ-026 SHALL, when SEG_SIGNED_MUX_LZB_EN is undefined, fix the sign at digit DIGITS-1 (BF or FF) and zero-pad the magnitude digits.

Structure
REQ-027 SHALL take the following from shared package seg_pkg:
- segment code constants (SEG_BLANK, SEG_MINUS, SEG_E, SEG_DIGIT table);
- SEG_W=8.
REQ-028 SHALL implement the shift-add-3 engine as sub-module seg_bin2bcd, which owns the busy timing and overflow detection.

Verification (DIGITS=4, VAL_W=12, REFRESH_DIV=4)
REQ-029 SHALL check reset: rst pulse -> segment=FF, an=1111, busy=0; after 4 cycles an=1110 and segment=C0.
REQ-030 SHALL check a negative value: load val_in=12'hFD6 (-42) -> busy high 13 cycles, then the display reads:
- LZB on, d3..d0: FF, BF, 99, A4;
- LZB off, d3..d0: BF, C0, 99, A4.
REQ-031 SHALL check overflow: load 1000, then load 12'h800 (-2048) -> d2..d0=86 in both cases; d3 is FF for the first and BF for the second.
REQ-032 SHALL check the busy guard: load 5, then load 7 three cycles later while busy -> display settles on 5 and busy falls once.
REQ-033 SHALL check reset mid-conversion: rst asserted on busy cycle 6 -> busy=0 immediately and display shows +0 (LZB on: d0=C0, others FF).
REQ-034 SHALL check scan rotation: steady value -> an cycles 1110, 1101, 1011, 0111, each held exactly 4 cycles, never two bits low.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment code constants, active-low {dp,g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int unsigned SEG_W = 8;

    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
    localparam logic [SEG_W-1:0] SEG_MINUS = 8'hBF;
    localparam logic [SEG_W-1:0] SEG_E     = 8'h86;

    localparam logic [SEG_W-1:0] SEG_DIGIT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // Non-decimal nibbles fall back to blank.
    function automatic logic [SEG_W-1:0] seg_numeral(input logic [3:0] d);
        logic [SEG_W-1:0] code;
        code = SEG_BLANK;
        if (d <= 4'd9) code = SEG_DIGIT[d];
        return code;
    endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// Busy lasts VAL_W+1 cycles; done_o marks the final busy cycle.
module seg_bin2bcd #(
    parameter int unsigned VAL_W = 12,
    parameter int unsigned ND    = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [VAL_W-1:0] mag_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [4*ND-1:0] bcd_o,
    output logic            ovf_o
);

    localparam int unsigned BW = 4 * ND;
    localparam int unsigned CW = $clog2(VAL_W + 2);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [VAL_W-1:0] bin_q, bin_d;
    logic [BW-1:0]    bcd_q, bcd_d, bcd_adj;
    logic             ovf_q, ovf_d;
    logic             last;

    assign last = (cnt_q == CW'(VAL_W));

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(ND); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        ovf_d  = ovf_q;
        if (!busy_q) begin
            if (start_i) begin
                busy_d = 1'b1;
                cnt_d  = '0;
                bin_d  = mag_i;
                bcd_d  = '0;
                ovf_d  = 1'b0;
            end
        end else if (last) begin
            busy_d = 1'b0;
        end else begin
            // A set MSB of the adjusted top digit is lost off the end: sticky overflow.
            bcd_d = {bcd_adj[BW-2:0], bin_q[VAL_W-1]};
            bin_d = {bin_q[VAL_W-2:0], 1'b0};
            ovf_d = ovf_q | bcd_adj[BW-1];
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            bin_q  <= '0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q & last;
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/seg_signed_mux.sv
// Multiplexed signed-decimal seven-segment display driver.
// Define SEG_SIGNED_MUX_LZB_EN for leading-zero blanking with a floating minus sign.
module seg_signed_mux
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned VAL_W       = 12,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VAL_W-1:0]  val_in,
    input  logic              load,
    output logic              busy,
    output logic [SEG_W-1:0]  segment,
    output logic [DIGITS-1:0] an
);

    localparam int unsigned ND = DIGITS - 1;
    localparam int unsigned BW = 4 * ND;
    localparam int unsigned IW = $clog2(DIGITS);
    localparam int unsigned CW = $clog2(REFRESH_DIV);

    logic             accept, done, conv_ovf;
    logic [VAL_W-1:0] mag;
    logic [BW-1:0]    conv_bcd;

    logic             sign_pend_q;
    logic             disp_sign_q, disp_ovf_q;
    logic [BW-1:0]    disp_bcd_q;

    logic [CW-1:0]     ref_cnt_q, ref_cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              scan_q, scan_d, wrap;
    logic [DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]  seg_q, seg_d, code, numeral, sign_code;
    logic [3:0]        dig;
    int unsigned       pos;

    assign accept = load & ~busy;
    assign mag    = val_in[VAL_W-1] ? (~val_in + VAL_W'(1)) : val_in;

    seg_bin2bcd #(
        .VAL_W (VAL_W),
        .ND    (ND)
    ) u_bin2bcd (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (accept),
        .mag_i   (mag),
        .busy_o  (busy),
        .done_o  (done),
        .bcd_o   (conv_bcd),
        .ovf_o   (conv_ovf)
    );

    // The first wrap after reset lights digit 0 without advancing the index.
    always_comb begin
        wrap      = (ref_cnt_q == CW'(REFRESH_DIV - 1));
        ref_cnt_d = wrap ? '0 : ref_cnt_q + CW'(1);
        scan_d    = scan_q | wrap;
        idx_d     = idx_q;
        if (wrap && scan_q) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        an_d = scan_d ? ~(DIGITS'(1) << idx_d) : '1;
    end

`ifdef SEG_SIGNED_MUX_LZB_EN
    int unsigned msd;

    always_comb begin
        msd = 0;
        for (int unsigned p = 0; p < ND; p++) begin
            if (disp_bcd_q[4*p +: 4] != 4'd0) msd = p;
        end
        if (disp_ovf_q) msd = ND - 1;
    end
`endif

    always_comb begin
        pos       = 32'(idx_d);
        dig       = '0;
        if (pos < ND) dig = disp_bcd_q[4*pos +: 4];
        numeral   = disp_ovf_q ? SEG_E : seg_numeral(dig);
        sign_code = disp_sign_q ? SEG_MINUS : SEG_BLANK;
`ifdef SEG_SIGNED_MUX_LZB_EN
        if (pos <= msd)          code = numeral;
        else if (pos == msd + 1) code = sign_code;
        else                     code = SEG_BLANK;
`else
        if (pos == DIGITS - 1) code = sign_code;
        else                   code = numeral;
`endif
        seg_d = scan_d ? code : SEG_BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_pend_q <= 1'b0;
            disp_sign_q <= 1'b0;
            disp_ovf_q  <= 1'b0;
            disp_bcd_q  <= '0;
        end else begin
            if (accept) sign_pend_q <= val_in[VAL_W-1];
            if (done) begin
                disp_sign_q <= sign_pend_q;
                disp_ovf_q  <= conv_ovf;
                disp_bcd_q  <= conv_bcd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q <= '0;
            idx_q     <= '0;
            scan_q    <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
            scan_q    <= scan_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an      = an_q;
    assign segment = seg_q;

endmodule
